// File: rtl/layer1_maxpool_if.sv
// Stream bundle between the conv layer, the 2x2 max-pool stage and the
// downstream buffer stage.
//   frame_start : sync pulse, next accepted pixel is (0,0)
//   din_valid   : datain carries a pixel this cycle
//   datain      : signed conv-layer pixel, raster order
//   dataout     : pooled 2x2 maximum (registered)
//   save        : dataout valid this cycle
//   frame_done  : pulse with the last pooled output of a frame
//   busy        : a frame is in progress
// master = pixel source side, slave = pooling stage.
interface layer1_maxpool_if #(
  parameter int DW = 16
);
  logic                 frame_start;
  logic                 din_valid;
  logic signed [DW-1:0] datain;
  logic signed [DW-1:0] dataout;
  logic                 save;
  logic                 frame_done;
  logic                 busy;

  modport master (
    output frame_start, din_valid, datain,
    input  dataout, save, frame_done, busy
  );

  modport slave (
    input  frame_start, din_valid, datain,
    output dataout, save, frame_done, busy
  );
endinterface

// File: rtl/layer1_maxpool.sv
// 2x2 / stride-2 signed max-pool over a raster-order feature map.
// Horizontal pairs are reduced through a hold register; the even-row pair
// maximum is parked in a half-width row buffer and combined with the odd-row
// pair maximum, giving one pooled output per window, one cycle after the
// pixel that completes it.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : layer1_maxpool_if.slave (pixel stream in, pooled stream out)
module layer1_maxpool #(
  parameter int DW    = 16,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  layer1_maxpool_if.slave    bus
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t               state;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic signed [DW-1:0] hreg;
  logic signed [DW-1:0] dout;
  logic                 save_q;
  logic                 fdone_q;
  logic                 busy_q;

  // Row pair buffer: one horizontal max per window column. Every entry is
  // written on the even row before the odd row reads it, so no reset.
  logic signed [DW-1:0] rowbuf [IMG_W/2];

  // Effective pixel position: a frame_start arriving with a pixel forces
  // that pixel to (0,0) regardless of where the counters were.
  logic [CW-1:0]        pc;
  logic [RW-1:0]        pr;
  logic                 col_last;
  logic                 row_last;
  logic                 wrap;
  logic signed [DW-1:0] hmax;
  logic signed [DW-1:0] rb_q;
  logic signed [DW-1:0] wmax;

  assign pc       = bus.frame_start ? '0 : col;
  assign pr       = bus.frame_start ? '0 : row;
  assign col_last = (pc == COL_LAST);
  assign row_last = (pr == ROW_LAST);
  assign wrap     = col_last && row_last;

  // Signed compares; on ties either operand is the same value.
  assign hmax = (bus.datain > hreg) ? bus.datain : hreg;
  assign rb_q = rowbuf[pc[CW-1:1]];
  assign wmax = (rb_q > hmax) ? rb_q : hmax;

  always_ff @(posedge clk) begin
    if (bus.din_valid && pc[0] && !pr[0])
      rowbuf[pc[CW-1:1]] <= hmax;
  end

  // Counters, datapath registers and the IDLE/ACTIVE frame FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      hreg    <= '0;
      dout    <= '0;
      save_q  <= 1'b0;
      fdone_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      save_q  <= 1'b0;
      fdone_q <= 1'b0;
      if (bus.din_valid) begin
        col <= col_last ? '0 : pc + 1'b1;
        if (col_last)
          row <= row_last ? '0 : pr + 1'b1;
        else
          row <= pr;

        if (!pc[0]) begin
          hreg <= bus.datain;
        end else if (pr[0]) begin
          dout    <= wmax;
          save_q  <= 1'b1;
          fdone_q <= wrap;
        end

        state  <= wrap ? IDLE : ACTIVE;
        // busy stays up through the frame_done cycle; a pixel accepted in
        // that same cycle keeps it up, so contiguous frames never drop it.
        busy_q <= 1'b1;
      end else if (bus.frame_start) begin
        // Resync: any partial window is abandoned without a save.
        col    <= '0;
        row    <= '0;
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        busy_q <= (state == ACTIVE);
      end
    end
  end

  assign bus.dataout    = dout;
  assign bus.save       = save_q;
  assign bus.frame_done = fdone_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_layer1_maxpool.sv
// Directed bench for layer1_maxpool: hand-built windows, ramp frames with
// and without gaps, frame_start resync, mid-frame reset, back-to-back frames.
module tb_layer1_maxpool;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer1_maxpool_if #(.DW(16)) bus();

  layer1_maxpool #(.DW(16), .IMG_W(24), .IMG_H(24)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nsave = 0;
  int busy_lo = 0;
  bit gap_en = 1'b0;
  bit watch = 1'b0;
  int eq_v[$];
  int eq_c[$];
  bit eq_f[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every save must match the next queued expectation,
  // including the cycle it was due in.
  always @(negedge clk) begin
    if (watch && !bus.busy) busy_lo++;
    if (bus.save) begin
      nsave++;
      if (eq_v.size() == 0) begin
        chk("stray_save", 1, 0);
      end else begin
        chk("dataout", int'(bus.dataout), eq_v.pop_front());
        chk("latency", cyc, eq_c.pop_front());
        chk("frame_done", int'(bus.frame_done), int'(eq_f.pop_front()));
        if (bus.frame_done) chk("busy_at_fd", int'(bus.busy), 1);
      end
    end else if (bus.frame_done) begin
      chk("fd_without_save", 1, 0);
    end
  end

  task automatic idle();
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.din_valid   = 1'b0;
  endtask

  task automatic fs_pulse();
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.din_valid   = 1'b0;
  endtask

  task automatic px(input int v, input bit fs, input bit has_exp, input int expv, input bit fd);
    if (gap_en)
      for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) idle();
    @(negedge clk);
    bus.frame_start = fs;
    bus.din_valid   = 1'b1;
    bus.datain      = 16'(v);
    if (has_exp) begin
      eq_v.push_back(expv);
      eq_c.push_back(cyc + 1);
      eq_f.push_back(fd);
    end
  endtask

  task automatic ramp_px(input int r, input int c, input bit fs);
    int k;
    bit done;
    k    = (r / 2) * 12 + c / 2;
    done = (r % 2 == 1) && (c % 2 == 1);
    px(r * 24 + c, fs, done, 24 * (2 * (k / 12) + 1) + 2 * (k % 12) + 1, done && (k == 143));
  endtask

  task automatic ramp_frame(input bit fs_first);
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++)
        ramp_px(r, c, fs_first && r == 0 && c == 0);
  endtask

  task automatic ramp_partial(input int n);
    for (int i = 0; i < n; i++) ramp_px(i / 24, i % 24, 1'b0);
  endtask

  task automatic close(input string tag, input int base, input int want);
    repeat (4) idle();
    chk({tag, "_saves"}, nsave - base, want);
    chk({tag, "_pending"}, eq_v.size(), 0);
    eq_v.delete();
    eq_c.delete();
    eq_f.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_dataout"}, int'(bus.dataout), 0);
    chk({tag, "_save"}, int'(bus.save), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int base;
    bus.frame_start = 1'b0;
    bus.din_valid   = 1'b0;
    bus.datain      = '0;

    #3;
    chk_reset_outs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Hand-built windows; each partial frame is abandoned with frame_start.
    base = nsave;
    px(-5, 0, 0, 0, 0);
    px(-3, 0, 0, 0, 0);
    for (int c = 2; c < 24; c++) px(c, 0, 0, 0, 0);
    px(-100, 0, 0, 0, 0);
    chk("busy_mid", int'(bus.busy), 1);
    px(-32768, 0, 1, -3, 0);
    fs_pulse();
    idle();
    chk("busy_after_fs", int'(bus.busy), 0);
    px(32767, 0, 0, 0, 0);
    px(-1, 0, 0, 0, 0);
    for (int c = 2; c < 24; c++) px(c, 0, 0, 0, 0);
    px(0, 0, 0, 0, 0);
    px(0, 0, 1, 32767, 0);
    fs_pulse();
    close("win", base, 2);
    chk("hold_win", int'(bus.dataout), 32767);

    // Gap-free ramp frame
    base = nsave;
    ramp_frame(1'b0);
    idle();
    idle();
    chk("busy_after_frame", int'(bus.busy), 0);
    close("ramp", base, 144);
    chk("hold_ramp", int'(bus.dataout), 575);

    // Ramp with random din_valid gaps
    base = nsave;
    gap_en = 1'b1;
    ramp_frame(1'b0);
    gap_en = 1'b0;
    close("gapped", base, 144);

    // frame_start alone after 50 pixels (row 1 windows already out)
    base = nsave;
    ramp_partial(50);
    fs_pulse();
    ramp_frame(1'b0);
    close("resync", base, 12 + 144);

    // frame_start coincident with the first pixel
    base = nsave;
    ramp_partial(50);
    ramp_frame(1'b1);
    close("resync_coinc", base, 12 + 144);

    // Reset after 300 pixels
    base = nsave;
    ramp_partial(300);
    idle();
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("mid_rst");
    idle();
    idle();
    chk_reset_outs("mid_rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    ramp_frame(1'b0);
    close("mid_rst", base, 72 + 144);

    // Back-to-back frames: busy must never drop between them
    base = nsave;
    busy_lo = 0;
    ramp_frame(1'b0);
    watch = 1'b1;
    ramp_frame(1'b0);
    watch = 1'b0;
    chk("b2b_busy_low", busy_lo, 0);
    close("b2b", base, 288);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
